// File: rtl/phy_mgmt_pkg.sv
// phy_mgmt_pkg: shared MDIO opcodes, register map and sequencer states for PHY management.
package phy_mgmt_pkg;
    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] OP_RD = 2'b10;
    localparam logic [4:0] REG_BMCR = 5'h00;
    localparam logic [4:0] REG_BMSR = 5'h01;
    localparam logic [4:0] REG_EXT_ADDR = 5'h1E;
    localparam logic [4:0] REG_EXT_DATA = 5'h1F;
    localparam int BMSR_LINK_BIT = 2;
    typedef enum logic [2:0] {
        RST_HOLD, RST_WAIT, WR_BMCR, WR_EXTA, WR_EXTD, POLL_WAIT, POLL_RD
    } state_t;
endpackage

// File: rtl/phy_mgmt_ctrl_mdio_master.sv
// mdio_master: shifts out one 64-bit clause-22 MDIO frame per start pulse and
// captures read data; abort drops the frame and returns the bus to idle at once.
module mdio_master
    import phy_mgmt_pkg::*;
#(
    parameter int unsigned MDC_DIV = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [1:0]  op,
    input  logic [4:0]  phyad,
    input  logic [4:0]  regad,
    input  logic [15:0] wdata,
    input  logic        mdio_i,
    output logic        done,
    output logic [15:0] rdata,
    output logic        no_ack,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe
);
    logic        busy, rd, mid, bit_end, rd_op;
    logic [31:0] cnt;
    logic [5:0]  bit_idx;
    logic [63:0] sh, frame;

    // read frames leave TA/data as ones; the PHY owns the line there
    always_comb begin
        rd_op = op == OP_RD;
        frame = {32'hFFFF_FFFF, 2'b01, op, phyad, regad,
                 rd_op ? 2'b11 : 2'b10, rd_op ? 16'hFFFF : wdata};
        mid = cnt == MDC_DIV - 1;
        bit_end = cnt == 2 * MDC_DIV - 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            rd <= 1'b0;
            cnt <= '0;
            bit_idx <= '0;
            sh <= '0;
            done <= 1'b0;
            rdata <= '0;
            no_ack <= 1'b0;
            mdc <= 1'b0;
            mdio_o <= 1'b1;
            mdio_oe <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                busy <= 1'b0;
                mdc <= 1'b0;
                mdio_o <= 1'b1;
                mdio_oe <= 1'b0;
            end else if (start && !busy) begin
                busy <= 1'b1;
                rd <= rd_op;
                cnt <= '0;
                bit_idx <= '0;
                sh <= frame;
                no_ack <= 1'b0;
                mdc <= 1'b0;
                mdio_o <= frame[63];
                mdio_oe <= 1'b1;
            end else if (busy) begin
                cnt <= bit_end ? '0 : cnt + 32'd1;
                if (mid) begin
                    mdc <= 1'b1;
                    if (rd && bit_idx == 6'd47) no_ack <= mdio_i;
                    if (rd && bit_idx >= 6'd48) rdata <= {rdata[14:0], mdio_i};
                end
                if (bit_end) begin
                    mdc <= 1'b0;
                    if (bit_idx == 6'd63) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        mdio_o <= 1'b1;
                        mdio_oe <= 1'b0;
                    end else begin
                        bit_idx <= bit_idx + 6'd1;
                        sh <= {sh[62:0], 1'b0};
                        mdio_o <= sh[62];
                        mdio_oe <= !(rd && bit_idx >= 6'd45);
                    end
                end
            end
        end
    end
endmodule

// File: rtl/phy_mgmt_ctrl.sv
// phy_mgmt_ctrl: PHY reset/boot sequencing, fixed MDIO configuration writes and
// periodic BMSR polling that exports link status.
module phy_mgmt_ctrl
    import phy_mgmt_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR = 5'd0,
    parameter int unsigned MDC_DIV = 50,
    parameter int unsigned RESET_HOLD_CYCLES = 1250000,
    parameter int unsigned RESET_WAIT_CYCLES = 12500000,
    parameter int unsigned POLL_CYCLES = 12500000,
    parameter logic [15:0] BMCR_VAL = 16'h1140,
    parameter logic [15:0] EXT_ADDR = 16'h000C,
    parameter logic [15:0] EXT_DATA = 16'h8001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        restart,
    output logic        phy_reset_n,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i,
    output logic        init_done,
    output logic        link_up,
    output logic [15:0] bmsr,
    output logic        mdio_err
);
    state_t      state, state_next;
    logic [31:0] cnt;
    logic        start, done, no_ack;
    logic [1:0]  op;
    logic [4:0]  regad;
    logic [15:0] wdata, rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RST_HOLD;
            cnt <= '0;
        end else begin
            state <= state_next;
            cnt <= (restart || state_next != state) ? '0 : cnt + 32'd1;
        end
    end

    always_comb begin
        state_next = state;
        if (restart) state_next = RST_HOLD;
        else case (state)
            RST_HOLD:  if (cnt == RESET_HOLD_CYCLES - 1) state_next = RST_WAIT;
            RST_WAIT:  if (cnt == RESET_WAIT_CYCLES - 1) state_next = WR_BMCR;
            WR_BMCR:   if (done) state_next = WR_EXTA;
            WR_EXTA:   if (done) state_next = WR_EXTD;
            WR_EXTD:   if (done) state_next = POLL_WAIT;
            POLL_WAIT: if (cnt == POLL_CYCLES - 1) state_next = POLL_RD;
            POLL_RD:   if (done) state_next = POLL_WAIT;
            default:   state_next = RST_HOLD;
        endcase
    end

    // frames start on the edge that enters WR_BMCR/POLL_RD; the later writes idle a full bit first
    always_comb begin
        start = !restart && ((state == RST_WAIT && cnt == RESET_WAIT_CYCLES - 1) ||
                ((state == WR_EXTA || state == WR_EXTD) && cnt == 2 * MDC_DIV - 1) ||
                (state == POLL_WAIT && cnt == POLL_CYCLES - 1));
        op = state == POLL_WAIT ? OP_RD : OP_WR;
        regad = state == RST_WAIT ? REG_BMCR : state == WR_EXTA ? REG_EXT_ADDR :
                state == WR_EXTD ? REG_EXT_DATA : REG_BMSR;
        wdata = state == WR_EXTA ? EXT_ADDR : state == WR_EXTD ? EXT_DATA : BMCR_VAL;
        phy_reset_n = state != RST_HOLD;
        init_done = state == POLL_WAIT || state == POLL_RD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            link_up <= 1'b0;
            bmsr <= '0;
            mdio_err <= 1'b0;
        end else if (restart) begin
            link_up <= 1'b0;
            mdio_err <= 1'b0;
        end else if (state == POLL_RD && done) begin
            if (no_ack) mdio_err <= 1'b1;
            else begin
                bmsr <= rdata;
                link_up <= rdata[BMSR_LINK_BIT];
            end
        end
    end

    mdio_master #(.MDC_DIV(MDC_DIV)) u_mdio (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(restart),
        .op(op),
        .phyad(PHY_ADDR),
        .regad(regad),
        .wdata(wdata),
        .mdio_i(mdio_i),
        .done(done),
        .rdata(rdata),
        .no_ack(no_ack),
        .mdc(mdc),
        .mdio_o(mdio_o),
        .mdio_oe(mdio_oe)
    );
endmodule

// File: tb/tb_phy_mgmt_ctrl.sv
// tb_phy_mgmt_ctrl: PHY model decodes MDIO frames, answers BMSR reads with random
// data or silence, and checks sequencing, status export, restart and async reset.
module tb_phy_mgmt_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, restart, mdio_i;
    logic        phy_reset_n, mdc, mdio_o, mdio_oe, init_done, link_up, mdio_err;
    logic [15:0] bmsr;

    logic [15:0] resp;
    logic        silent, is_rd, mdc_q;
    logic [63:0] cap, msk;
    int          nbits;
    logic [63:0] fr_q[$], oe_q[$];
    int          n_chk = 0, n_pass = 0;
    logic [15:0] exp_bmsr;
    logic        exp_link, exp_err;

    localparam logic [63:0] WR_MASK = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] RD_MASK = 64'hFFFF_FFFF_FFFC_0000;
    localparam logic [45:0] RD_HDR = {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd1, 5'd1};

    phy_mgmt_ctrl #(
        .PHY_ADDR(5'd1), .MDC_DIV(2), .RESET_HOLD_CYCLES(20),
        .RESET_WAIT_CYCLES(10), .POLL_CYCLES(100)
    ) dut (
        .clk(clk), .rst_n(rst_n), .restart(restart), .phy_reset_n(phy_reset_n),
        .mdc(mdc), .mdio_o(mdio_o), .mdio_oe(mdio_oe), .mdio_i(mdio_i),
        .init_done(init_done), .link_up(link_up), .bmsr(bmsr), .mdio_err(mdio_err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] wr_frame(input logic [4:0] ra, input logic [15:0] d);
        return {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd1, ra, 2'b10, d};
    endfunction

    // PHY side: record every bit on mdc rise, reply during read TA/data
    always @(posedge clk) begin
        #1;
        if (!rst_n || restart) begin
            nbits = 0;
            is_rd = 1'b0;
        end else if (mdc && !mdc_q) begin
            cap = {cap[62:0], mdio_o};
            msk = {msk[62:0], mdio_oe};
            nbits++;
            if (nbits == 36) is_rd = cap[1:0] == 2'b10;
            if (nbits == 64) begin
                fr_q.push_back(cap);
                oe_q.push_back(msk);
                nbits = 0;
                is_rd = 1'b0;
            end
        end
        mdc_q = mdc;
    end

    always_comb begin
        mdio_i = 1'b1;
        if (is_rd && nbits >= 47 && nbits < 64 && !silent)
            mdio_i = nbits == 47 ? 1'b0 : resp[4'(63 - nbits)];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_frames(input int k);
        int n = 0;
        while (fr_q.size() < k && n < 5000) begin
            tick();
            n++;
        end
        chk("frame_arrived", 64'(fr_q.size() >= k), 64'd1);
    endtask

    task automatic count_hold();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!phy_reset_n && n < 1000);
        chk("rst_hold_len", 64'(n), 64'd20);
    endtask

    task automatic check_writes(input int base);
        int n = 0;
        wait_frames(base + 3);
        chk("wr_bmcr", fr_q[base], wr_frame(5'h00, 16'h1140));
        chk("wr_exta", fr_q[base + 1], wr_frame(5'h1E, 16'h000C));
        chk("wr_extd", fr_q[base + 2], wr_frame(5'h1F, 16'h8001));
        for (int i = 0; i < 3; i++) chk("wr_oe", oe_q[base + i], WR_MASK);
        chk("init_done_before_end", 64'(init_done), 64'd0);
        while (!init_done && n < 20) begin
            tick();
            n++;
        end
        chk("init_done_rise", 64'(init_done), 64'd1);
    endtask

    initial begin
        int n, p;
        rst_n = 1'b0;
        restart = 1'b0;
        silent = 1'b0;
        resp = 16'h796D;
        nbits = 0;
        is_rd = 1'b0;
        mdc_q = 1'b0;
        exp_bmsr = '0;
        exp_link = 1'b0;
        exp_err = 1'b0;
        repeat (3) tick();
        chk("reset_outs", 64'({phy_reset_n, mdc, mdio_o, mdio_oe, init_done, link_up, mdio_err}), 64'b0010000);
        chk("reset_bmsr", 64'(bmsr), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        count_hold();
        n = 0;
        do begin
            tick();
            n++;
        end while (!mdc && n < 1000);
        chk("first_mdc_rise", 64'(n), 64'd12);
        check_writes(0);
        p = 3;
        for (int i = 0; i < 6; i++) begin
            wait_frames(p + 1);
            chk("rd_header", 64'(fr_q[p][63:18]), 64'(RD_HDR));
            chk("rd_oe", oe_q[p], RD_MASK);
            p++;
            repeat (4) tick();
            if (silent) exp_err = 1'b1;
            else begin
                exp_bmsr = resp;
                exp_link = resp[2];
            end
            chk("bmsr", 64'(bmsr), 64'(exp_bmsr));
            chk("link_up", 64'(link_up), 64'(exp_link));
            chk("mdio_err", 64'(mdio_err), 64'(exp_err));
            resp = 16'($urandom);
            silent = i == 0 ? 1'b1 : ($urandom_range(0, 2) == 0);
        end
        silent = 1'b0;
        @(negedge clk) restart = 1'b1;
        tick();
        exp_link = 1'b0;
        exp_err = 1'b0;
        chk("restart_outs", 64'({phy_reset_n, mdc, mdio_oe, init_done, link_up, mdio_err}), 64'd0);
        chk("restart_bmsr_kept", 64'(bmsr), 64'(exp_bmsr));
        @(negedge clk) restart = 1'b0;
        count_hold();
        p = fr_q.size();
        wait_frames(p + 1);
        n = 0;
        while (nbits != 40 && n < 2000) begin
            tick();
            n++;
        end
        chk("reached_bit40", 64'(nbits), 64'd40);
        chk("exta_oe_bit40", 64'(mdio_oe), 64'd1);
        @(negedge clk) restart = 1'b1;
        tick();
        chk("midframe_restart", 64'({phy_reset_n, mdc, mdio_oe, init_done}), 64'd0);
        @(negedge clk) restart = 1'b0;
        count_hold();
        p = fr_q.size();
        check_writes(p);
        n = 0;
        while (nbits < 20 && n < 2000) begin
            tick();
            n++;
        end
        chk("mid_poll", 64'(nbits >= 20), 64'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_reset_outs", 64'({phy_reset_n, mdc, mdio_o, mdio_oe, init_done, link_up, mdio_err}), 64'b0010000);
        chk("async_reset_bmsr", 64'(bmsr), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        count_hold();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
